// File: rtl/ps2_ascii_tx_queue_if.sv
// Byte-stream interface between the PS/2 receiver / UART transmitter and the
// ASCII queue: scancode strobe in, UART data/start/busy handshake.
interface ps2_ascii_tx_queue_if;
  logic [7:0] scancode;
  logic       new_code;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    output scancode, new_code, tx_busy,
    input  tx_data, tx_start
  );

  modport slave (
    input  scancode, new_code, tx_busy,
    output tx_data, tx_start
  );
endinterface

// File: rtl/ps2_ascii_tx_queue.sv
// PS/2 Set-2 scancode to ASCII translator with a FIFO feeding a UART.
// Optional caps-lock toggle on scancode 58 when PS2_CAPS_LOCK_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a queued byte and an idle UART
// START   | tx_start pulse, tx_data holds the popped byte
// WAIT_HI | waiting for tx_busy to rise, bounded by BUSY_WAIT cycles
// WAIT_LO | waiting for the UART to finish the byte
module ps2_ascii_tx_queue #(
  parameter int FIFO_DEPTH = 16,
  parameter int BUSY_WAIT  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ps2_ascii_tx_queue_if.slave         bus,
  output logic [7:0]                  last_ascii,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  // {mapped, is_letter, ascii} for the unshifted Set-2 code
  function automatic logic [9:0] map_code(input logic [7:0] c);
    case (c)
      8'h1C: map_code = {2'b11, 8'h61}; 8'h32: map_code = {2'b11, 8'h62};
      8'h21: map_code = {2'b11, 8'h63}; 8'h23: map_code = {2'b11, 8'h64};
      8'h24: map_code = {2'b11, 8'h65}; 8'h2B: map_code = {2'b11, 8'h66};
      8'h34: map_code = {2'b11, 8'h67}; 8'h33: map_code = {2'b11, 8'h68};
      8'h43: map_code = {2'b11, 8'h69}; 8'h3B: map_code = {2'b11, 8'h6A};
      8'h42: map_code = {2'b11, 8'h6B}; 8'h4B: map_code = {2'b11, 8'h6C};
      8'h3A: map_code = {2'b11, 8'h6D}; 8'h31: map_code = {2'b11, 8'h6E};
      8'h44: map_code = {2'b11, 8'h6F}; 8'h4D: map_code = {2'b11, 8'h70};
      8'h15: map_code = {2'b11, 8'h71}; 8'h2D: map_code = {2'b11, 8'h72};
      8'h1B: map_code = {2'b11, 8'h73}; 8'h2C: map_code = {2'b11, 8'h74};
      8'h3C: map_code = {2'b11, 8'h75}; 8'h2A: map_code = {2'b11, 8'h76};
      8'h1D: map_code = {2'b11, 8'h77}; 8'h22: map_code = {2'b11, 8'h78};
      8'h35: map_code = {2'b11, 8'h79}; 8'h1A: map_code = {2'b11, 8'h7A};
      8'h45: map_code = {2'b10, 8'h30}; 8'h16: map_code = {2'b10, 8'h31};
      8'h1E: map_code = {2'b10, 8'h32}; 8'h26: map_code = {2'b10, 8'h33};
      8'h25: map_code = {2'b10, 8'h34}; 8'h2E: map_code = {2'b10, 8'h35};
      8'h36: map_code = {2'b10, 8'h36}; 8'h3D: map_code = {2'b10, 8'h37};
      8'h3E: map_code = {2'b10, 8'h38}; 8'h46: map_code = {2'b10, 8'h39};
      8'h29: map_code = {2'b10, 8'h20}; 8'h5A: map_code = {2'b10, 8'h0D};
      8'h66: map_code = {2'b10, 8'h08};
      default: map_code = 10'h000;
    endcase
  endfunction

  logic           brk, ext, shift, caps;
  logic           key_byte, is_shift, upper, push, push_ok, pop, full, empty;
  logic [9:0]     lookup;
  logic [7:0]     push_char;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [TW-1:0]  tmr;
  state_t         state, state_nx;

  // Key-byte classification and ASCII selection for the current strobe
  always_comb begin
    key_byte  = bus.new_code && (bus.scancode != 8'hF0) && (bus.scancode != 8'hE0);
    is_shift  = (bus.scancode == 8'h12) || (bus.scancode == 8'h59);
    lookup    = map_code(bus.scancode);
    upper     = shift ^ caps;
    push      = key_byte && !brk && !ext && lookup[9];
    push_char = (lookup[8] && upper) ? (lookup[7:0] - 8'h20) : lookup[7:0];
    full      = (fifo_count == (AW+1)'(FIFO_DEPTH));
    empty     = (fifo_count == '0);
    push_ok   = push && !full;
  end

  // Make/break prefix flags and shift tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      brk   <= 1'b0;
      ext   <= 1'b0;
      shift <= 1'b0;
    end else if (bus.new_code) begin
      if (bus.scancode == 8'hF0) begin
        brk <= 1'b1;
      end else if (bus.scancode == 8'hE0) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
        if (!ext && is_shift) shift <= !brk;
      end
    end
  end

`ifdef PS2_CAPS_LOCK_EN
  // Caps lock toggles on each make of 58; its break is ignored
  always_ff @(posedge clk) begin
    if (!rst_n)                                              caps <= 1'b0;
    else if (key_byte && !brk && !ext && bus.scancode == 8'h58) caps <= !caps;
  end
`else
  assign caps = 1'b0;
`endif

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_char;
  end

  // FIFO pointers, occupancy, last character and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      last_ascii <= 8'h00;
    end else begin
      if (push)            last_ascii <= push_char;
      if (push && full)    overflow   <= 1'b1;
      if (push_ok)         wr_ptr     <= wr_ptr + 1'b1;
      if (pop)             rd_ptr     <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // TX FSM next state, pop request and start pulse
  always_comb begin
    state_nx     = state;
    pop          = 1'b0;
    bus.tx_start = 1'b0;
    case (state)
      IDLE: if (!empty && !bus.tx_busy) begin
        pop      = 1'b1;
        state_nx = START;
      end
      START: begin
        bus.tx_start = 1'b1;
        state_nx     = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.tx_busy)      state_nx = WAIT_LO;
        else if (tmr == '0)   state_nx = IDLE;
      end
      WAIT_LO: if (!bus.tx_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // TX FSM state, busy-rise timeout down-counter and held output byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmr         <= '0;
      bus.tx_data <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == START)                 tmr <= TW'(BUSY_WAIT - 1);
      else if (state == WAIT_HI && tmr != '0) tmr <= tmr - 1'b1;
      if (pop) bus.tx_data <= mem[rd_ptr];
    end
  end
endmodule

// File: tb/tb_ps2_ascii_tx_queue.sv
// Directed bench for ps2_ascii_tx_queue with a simple UART busy responder.
module tb_ps2_ascii_tx_queue;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] last_ascii;
   logic [4:0] fifo_count;
   logic       overflow;

   ps2_ascii_tx_queue_if ifc();

   ps2_ascii_tx_queue #(.FIFO_DEPTH(16), .BUSY_WAIT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (ifc.slave),
      .last_ascii (last_ascii),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART model: 0 = busy for 100 cycles after each start, 1 = forced busy, 2 = forced idle
   int         busy_mode = 0;
   int         busy_cnt  = 0;
   int         cyc       = 0;
   int         unstable  = 0;
   logic [7:0] held;
   logic [7:0] cap_q [$];
   int         t_q   [$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (ifc.tx_start) begin
         cap_q.push_back(ifc.tx_data);
         t_q.push_back(cyc);
         held = ifc.tx_data;
      end else if (busy_cnt > 0 && ifc.tx_data !== held) begin
         unstable++;
      end
      case (busy_mode)
         1: begin ifc.tx_busy = 1'b1; busy_cnt = 0; end
         2: begin ifc.tx_busy = 1'b0; busy_cnt = 0; end
         default: begin
            if (ifc.tx_start)      busy_cnt = 100;
            else if (busy_cnt > 0) busy_cnt--;
            ifc.tx_busy = (busy_cnt > 0);
         end
      endcase
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] code);
      @(posedge clk); #1;
      ifc.scancode = code;
      ifc.new_code = 1'b1;
      @(posedge clk); #1;
      ifc.new_code = 1'b0;
   endtask

   int base;

   initial begin
      ifc.scancode = 8'h00;
      ifc.new_code = 1'b0;
      ifc.tx_busy  = 1'b0;
      rst_n        = 1'b0;
      wait_cycles(3);
      chk("reset_tx_data", ifc.tx_data, 8'h00);
      chk("reset_tx_start", ifc.tx_start, 1'b0);
      chk("reset_last_ascii", last_ascii, 8'h00);
      chk("reset_fifo_count", fifo_count, 5'd0);
      chk("reset_overflow", overflow, 1'b0);
      rst_n = 1'b1;
      wait_cycles(2);

      // single key make/break
      base = cap_q.size();
      strobe(8'h1C);
      chk("t1_last_ascii_latency", last_ascii, 8'h61);
      chk("t1_count_after_push", fifo_count, 5'd1);
      strobe(8'hF0);
      strobe(8'h1C);
      wait_cycles(250);
      chk("t1_num_starts", cap_q.size() - base, 1);
      chk("t1_byte", cap_q[base], 8'h61);
      chk("t1_last_ascii", last_ascii, 8'h61);
      chk("t1_count_empty", fifo_count, 5'd0);

      // shift held then released
      base = cap_q.size();
      strobe(8'h12); strobe(8'h1C); strobe(8'hF0); strobe(8'h1C);
      strobe(8'hF0); strobe(8'h12); strobe(8'h1C);
      wait_cycles(400);
      chk("t2_num_starts", cap_q.size() - base, 2);
      chk("t2_byte0", cap_q[base], 8'h41);
      chk("t2_byte1", cap_q[base+1], 8'h61);

      // extended make/break ignored
      base = cap_q.size();
      strobe(8'hE0); strobe(8'h75); strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
      strobe(8'h29);
      wait_cycles(300);
      chk("t3_num_starts", cap_q.size() - base, 1);
      chk("t3_byte", cap_q[base], 8'h20);
      chk("t3_last_ascii", last_ascii, 8'h20);

      // overflow with UART held busy
      busy_mode = 1;
      wait_cycles(3);
      base = cap_q.size();
      for (int i = 0; i < 16; i++) strobe(8'h16);
      chk("t4_count_full", fifo_count, 5'd16);
      chk("t4_overflow_not_yet", overflow, 1'b0);
      strobe(8'h16);
      strobe(8'h16);
      chk("t4_count_still_full", fifo_count, 5'd16);
      chk("t4_overflow_set", overflow, 1'b1);
      chk("t4_last_ascii", last_ascii, 8'h31);
      busy_mode = 0;
      wait_cycles(2000);
      chk("t4_num_starts", cap_q.size() - base, 16);
      for (int i = 0; i < 16; i++) chk("t4_byte", cap_q[base+i], 8'h31);
      chk("t4_overflow_sticky", overflow, 1'b1);
      chk("t4_count_drained", fifo_count, 5'd0);

      // busy never rises: timeout path
      busy_mode = 2;
      wait_cycles(3);
      base = cap_q.size();
      strobe(8'h5A);
      wait_cycles(1);
      chk("t5_start_high", ifc.tx_start, 1'b1);
      chk("t5_data", ifc.tx_data, 8'h0D);
      wait_cycles(1);
      chk("t5_start_one_cycle", ifc.tx_start, 1'b0);
      strobe(8'h29);
      wait_cycles(40);
      chk("t5_num_starts", cap_q.size() - base, 2);
      chk("t5_byte1", cap_q[base+1], 8'h20);
      chk("t5_start_spacing", t_q[base+1] - t_q[base], 18);

      // reset with bytes queued
      busy_mode = 1;
      wait_cycles(3);
      strobe(8'h16); strobe(8'h16); strobe(8'h16);
      chk("t5_count_queued", fifo_count, 5'd3);
      base = cap_q.size();
      rst_n = 1'b0;
      wait_cycles(1);
      rst_n = 1'b1;
      busy_mode = 2;
      chk("t5_reset_count", fifo_count, 5'd0);
      chk("t5_reset_overflow", overflow, 1'b0);
      chk("t5_reset_last_ascii", last_ascii, 8'h00);
      wait_cycles(50);
      chk("t5_no_start_after_reset", cap_q.size() - base, 0);

      // caps lock
      busy_mode = 0;
      wait_cycles(3);
      base = cap_q.size();
`ifdef PS2_CAPS_LOCK_EN
      strobe(8'h58); strobe(8'h1C);
      strobe(8'h12); strobe(8'h1C);
      wait_cycles(300);
      chk("t6_num_starts", cap_q.size() - base, 2);
      chk("t6_caps_byte", cap_q[base], 8'h41);
      chk("t6_caps_shift_byte", cap_q[base+1], 8'h61);
`else
      strobe(8'h58); strobe(8'h1C);
      wait_cycles(200);
      chk("t6_num_starts", cap_q.size() - base, 1);
      chk("t6_nocaps_byte", cap_q[base], 8'h61);
`endif
      chk("tx_data_stable_while_busy", unstable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_ascii_tx_queue.md
Name: ps2_ascii_tx_queue

Overview:
- Sits between the PS/2 scancode receiver (scancode[7:0] plus a one-cycle new_code strobe) and the UART transmitter (data, start, busy).
- Decodes Set-2 make/break sequences and tracks Shift.
- Translates printable keys to ASCII, buffers the characters in a FIFO, and feeds the UART one byte at a time.
- Replaces the button-driven send path, so typed keys stream directly out of RsTx.

Parameters:
- FIFO_DEPTH, 16, number of ASCII entries buffered. Must be a power of two, range 2 to 64.
- BUSY_WAIT, 16, maximum cycles to wait for tx_busy to rise after tx_start before treating the byte as sent.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- scancode  in  8  byte from the PS/2 receiver.
- new_code  in  1  one-cycle strobe; scancode is valid in that cycle.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte presented to the UART. Held stable from tx_start until the byte completes.
- tx_start  out  1  one-cycle start pulse to the UART.
- last_ascii  out  8  most recent character pushed into the FIFO (for LED/7-seg display).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag; set when a character is dropped because the FIFO is full.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: tx_data=0, tx_start=0, last_ascii=0, fifo_count=0, overflow=0.
  - Internal: shift=0, both decoder flags cleared, TX FSM to IDLE.
  - Reset mid-transmission drops the FIFO contents. The UART byte already in flight is not aborted.
- Decoder (acts only in cycles with new_code=1):
  - F0: set brk=1 and consume the byte.
  - E0: set ext=1 and consume the byte.
  - Any other byte is a key byte; brk and ext are cleared after it is processed.
  - Shift keys 12 and 59 (ext=0): make sets shift=1; break clears shift.
  - Break of any other key: ignored.
  - Make with ext=1: ignored.
  - Make with ext=0 and a mapped code: push one ASCII byte.
  - Unmapped codes: ignored.
- Map, shift=0:
  - Letters to 'a'-'z' (1C=a, 32=b, 21=c, 23=d, 24=e, 2B=f, 34=g, 33=h, 43=i, 3B=j, 42=k, 4B=l, 3A=m, 31=n, 44=o, 4D=p, 15=q, 2D=r, 1B=s, 2C=t, 3C=u, 2A=v, 1D=w, 22=x, 35=y, 1A=z).
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - Controls: 29=0x20, 5A=0x0D, 66=0x08.
- Map, shift=1: letters become uppercase (ASCII minus 0x20). Digits and controls are unchanged.
- Typematic repeats: each repeated make byte is a separate push.
- Latency: push takes effect one clk after the new_code cycle. last_ascii updates in that same cycle, even if the byte is dropped.
- FIFO:
  - Circular buffer with wrap-around pointers of width log2(FIFO_DEPTH).
  - Push while full: drop the byte and set overflow=1. overflow clears only on reset.
  - Simultaneous push and pop while full: the push is still dropped, because fullness is evaluated before the pop.
  - Simultaneous push and pop while not full: both occur and fifo_count is unchanged.
- TX FSM:
  - IDLE: when FIFO non-empty and tx_busy=0, pop the head into tx_data and go to START.
  - START: tx_start=1 for exactly one cycle, then go to WAIT_HI.
  - WAIT_HI: go to WAIT_LO when tx_busy=1. Go to IDLE after BUSY_WAIT cycles without busy (timeout).
  - WAIT_LO: go to IDLE when tx_busy=0.
  - At most one byte is in flight. Minimum spacing between tx_start pulses is 3 cycles plus the UART busy time.

Optional Feature:
- Macro: PS2_CAPS_LOCK_EN.
- Defined:
  - Make of scancode 58 (ext=0) toggles an internal caps register, cleared on reset.
  - Letter case is determined by shift XOR caps. Digits are unaffected.
  - Break of 58 is ignored.
- Undefined: 58 is an unmapped code and has no effect. No caps register is synthesised.

Test Plan:
- Strobe 1C, F0, 1C with tx_busy pulsed high for 100 cycles after each tx_start -> exactly one tx_start, tx_data=0x61, last_ascii=0x61, fifo_count returns to 0.
- Strobe 12, 1C, F0, 1C, F0, 12, 1C -> transmitted bytes 0x41 then 0x61.
- Strobe E0, 75, E0, F0, 75, then 29 -> only 0x20 is sent.
- Hold tx_busy=1 and push FIFO_DEPTH+2 make codes of 16 -> fifo_count=16, overflow=1. Release busy -> exactly 16 bytes of 0x31, overflow stays 1.
- Keep tx_busy=0 and push 5A -> tx_start asserted, BUSY_WAIT timeout taken, FSM returns to IDLE, the next byte is served. Assert rst_n=0 with 3 bytes queued -> no further tx_start, fifo_count=0.
- With PS2_CAPS_LOCK_EN: strobe 58, 1C -> 0x41. Then 12, 1C -> 0x61. Without the macro, 58, 1C -> 0x61.
